// File: rtl/sync_edge_detect.sv
`timescale 1ns/1ps
// Level synchronizer with registered rise/fall/selected-edge pulse outputs.
// SYNC_STAGES flops resynchronize din; one history flop feeds edge detection.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 2
) (
   input  logic clock,
   input  logic rst,
   input  logic din,
   output logic flag,
   output logic rise,
   output logic fall
);

   if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("sync_edge_detect: SYNC_STAGES must be >= 2");
   end
   if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
      $error("sync_edge_detect: EDGE_MODE must be 0, 1 or 2");
   end

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   dp_q;
   logic                   ds;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   flag_q, flag_d;

   assign ds = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
      rise_d = ds & ~dp_q;
      fall_d = ~ds & dp_q;
      case (EDGE_MODE)
         0:       flag_d = rise_d;
         1:       flag_d = fall_d;
         default: flag_d = rise_d | fall_d;
      endcase
   end

   // NOTE: non-blocking assignments so every flop samples the pre-edge values of its neighbours.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         dp_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         flag_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         dp_q   <= ds;
         rise_q <= rise_d;
         fall_q <= fall_d;
         flag_q <= flag_d;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;
   assign flag = flag_q;

endmodule

// File: tb/tb_sync_edge_detect.sv
`timescale 1ns/1ps
// Directed bench: three instances (both/rise-only/fall-only edge modes) share one stimulus;
// outputs are sampled on falling clock edges against hand-derived pulse windows.
module tb_sync_edge_detect;

   logic clock;
   logic rst;
   logic din;
   logic flag_b, rise_b, fall_b;
   logic flag_r, rise_r, fall_r;
   logic flag_f, rise_f, fall_f;

   int checks = 0;
   int errors = 0;

   sync_edge_detect #(.SYNC_STAGES(2), .EDGE_MODE(2)) dut_both (
      .clock(clock), .rst(rst), .din(din), .flag(flag_b), .rise(rise_b), .fall(fall_b)
   );
   sync_edge_detect #(.SYNC_STAGES(2), .EDGE_MODE(0)) dut_rise (
      .clock(clock), .rst(rst), .din(din), .flag(flag_r), .rise(rise_r), .fall(fall_r)
   );
   sync_edge_detect #(.SYNC_STAGES(2), .EDGE_MODE(1)) dut_fall (
      .clock(clock), .rst(rst), .din(din), .flag(flag_f), .rise(rise_f), .fall(fall_f)
   );

   // Rising edges at 10, 30, 50, ...; falling edges (sample points) at 20, 40, ...
   initial begin
      clock = 1'b0;
      forever #10 clock = ~clock;
   end

   task automatic wait_until(input longint unsigned t);
      if ($time < t) #(t - $time);
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Expected rise/fall are hand-derived; flag follows from each instance's edge mode.
   task automatic check_all(input string tag, input logic er, input logic ef);
      check_bit({tag, "/both.rise"}, rise_b, er);
      check_bit({tag, "/both.fall"}, fall_b, ef);
      check_bit({tag, "/both.flag"}, flag_b, er | ef);
      check_bit({tag, "/rmode.rise"}, rise_r, er);
      check_bit({tag, "/rmode.fall"}, fall_r, ef);
      check_bit({tag, "/rmode.flag"}, flag_r, er);
      check_bit({tag, "/fmode.rise"}, rise_f, er);
      check_bit({tag, "/fmode.fall"}, fall_f, ef);
      check_bit({tag, "/fmode.flag"}, flag_f, ef);
   endtask

   initial begin
      rst = 1'b0;
      din = 1'b0;

      // Reset window 8..23 ns; din rises during reset and is first captured at 30 ns.
      wait_until(8);   rst = 1'b1;
      wait_until(9);   check_all("reset_asserted", 1'b0, 1'b0);
      wait_until(15);  din = 1'b1;
      wait_until(20);  check_all("reset_held", 1'b0, 1'b0);
      wait_until(23);  rst = 1'b0;

      // Captures at 30/50/70/110/130 -> rise 70-90, fall 90-110, rise 110-130, fall 150-170, rise 170-190.
      wait_until(40);  check_all("seq_t40", 1'b0, 1'b0);  din = 1'b0;
      wait_until(60);  check_all("seq_t60", 1'b0, 1'b0);
      wait_until(65);  din = 1'b1;
      wait_until(80);  check_all("seq_t80_rise", 1'b1, 1'b0);
      wait_until(95);  din = 1'b0;
      wait_until(100); check_all("seq_t100_fall", 1'b0, 1'b1);
      wait_until(120); check_all("seq_t120_rise", 1'b1, 1'b0);  din = 1'b1;
      wait_until(140); check_all("seq_t140", 1'b0, 1'b0);
      wait_until(160); check_all("seq_t160_fall", 1'b0, 1'b1);
      wait_until(180); check_all("seq_t180_rise", 1'b1, 1'b0);
      wait_until(200); check_all("seq_t200", 1'b0, 1'b0);

      // Reset with din held high: deassert at 243, edges 250/270/290 -> single rise 290-310.
      wait_until(210); rst = 1'b1;
      wait_until(211); check_all("rst_din_high_assert", 1'b0, 1'b0);
      wait_until(240); check_all("rst_din_high_held", 1'b0, 1'b0);
      wait_until(243); rst = 1'b0;
      wait_until(260); check_all("post_rst_t260", 1'b0, 1'b0);
      wait_until(280); check_all("post_rst_t280", 1'b0, 1'b0);
      wait_until(300); check_all("post_rst_rise", 1'b1, 1'b0);
      wait_until(320); check_all("post_rst_t320", 1'b0, 1'b0);
      wait_until(340); check_all("post_rst_t340", 1'b0, 1'b0);

      // Fall pulse 390-410, cut short by reset at 402; nothing may follow after release.
      wait_until(345); din = 1'b0;
      wait_until(380); check_all("pre_fall_t380", 1'b0, 1'b0);
      wait_until(400); check_all("mid_fall_t400", 1'b0, 1'b1);
      wait_until(402); rst = 1'b1;
      wait_until(403); check_all("mid_pulse_reset", 1'b0, 1'b0);
      wait_until(420); check_all("mid_pulse_held", 1'b0, 1'b0);
      wait_until(423); rst = 1'b0;
      wait_until(440); check_all("after_release_t440", 1'b0, 1'b0);
      wait_until(460); check_all("after_release_t460", 1'b0, 1'b0);
      wait_until(480); check_all("after_release_t480", 1'b0, 1'b0);

      // Toggle din every 20 ns (495..675): captures 510..690 give alternating pulses 550..750.
      for (int i = 0; i < 14; i++) begin
         wait_until(495 + 20 * i);
         if (i < 10) din = ~din;
         wait_until(500 + 20 * i);
         if (i < 3 || i == 13)
            check_all($sformatf("stress_t%0d_idle", 500 + 20 * i), 1'b0, 1'b0);
         else if (((i - 3) % 2) == 0)
            check_all($sformatf("stress_t%0d_rise", 500 + 20 * i), 1'b1, 1'b0);
         else
            check_all($sformatf("stress_t%0d_fall", 500 + 20 * i), 1'b0, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
